iq_demod_accumulator: RTL

//  Quadrature demodulator stage that sits directly downstream of the sin/cos DCO.

---
 rtl/iq_demod_accumulator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/iq_demod_accumulator.sv
// I/Q demodulator: sample x DCO cos/sin, integrated over a programmable window of N samples.
// Latency: 2 CE cycles from the last SAMPLE_VALID to OUT_VALID. No backpressure; CE=0 freezes all state.
// Build option IQ_ACC_SATURATE_EN: saturating accumulators (default: two's-complement wrap).
module iq_demod_accumulator #(
  parameter int SAMPLE_BITS = 16,
  parameter int TRIG_BITS   = 13,
  parameter int ACC_BITS    = 40,
  parameter int PERIOD_BITS = 16
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          CE,
  input  logic signed [SAMPLE_BITS-1:0] SAMPLE_IN,
  input  logic                          SAMPLE_VALID,
  input  logic signed [TRIG_BITS-1:0]   SIN_VALUE,
  input  logic signed [TRIG_BITS-1:0]   COS_VALUE,
  input  logic [PERIOD_BITS-1:0]        PERIOD_IN,
  input  logic                          PERIOD_WE,
  output logic signed [ACC_BITS-1:0]    I_OUT,
  output logic signed [ACC_BITS-1:0]    Q_OUT,
  output logic                          OUT_VALID,
  output logic                          OVF_OUT
);

  localparam int PROD_BITS = SAMPLE_BITS + TRIG_BITS;

  typedef enum logic {IDLE, RUN} state_e;

  // Returns {overflow, sum}; overflow is judged on the raw wrapped sum.
  function automatic logic [ACC_BITS:0] acc_add(input logic signed [ACC_BITS-1:0] a,
                                                input logic signed [ACC_BITS-1:0] b);
    logic signed [ACC_BITS-1:0] s;
    logic                       ovf;
    s   = a + b;
    ovf = (a[ACC_BITS-1] == b[ACC_BITS-1]) && (s[ACC_BITS-1] != a[ACC_BITS-1]);
`ifdef IQ_ACC_SATURATE_EN
    if (ovf) begin
      s = a[ACC_BITS-1] ? {1'b1, {(ACC_BITS-1){1'b0}}} : {1'b0, {(ACC_BITS-1){1'b1}}};
    end
`endif
    return {ovf, s};
  endfunction

  state_e                       state_q, state_d;
  logic [PERIOD_BITS-1:0]       period_q, period_d;
  logic [PERIOD_BITS-1:0]       cnt_q, cnt_d;
  logic signed [ACC_BITS-1:0]   sum_i_q, sum_i_d, sum_q_q, sum_q_d;
  logic                         win_ovf_q, win_ovf_d;
  logic signed [PROD_BITS-1:0]  pi_q, pi_d, pq_q, pq_d;
  logic                         v1_q, v1_d;
  logic signed [ACC_BITS-1:0]   i_out_q, i_out_d, q_out_q, q_out_d;
  logic                         out_valid_q, out_valid_d;
  logic                         ovf_out_q, ovf_out_d;

  logic signed [ACC_BITS-1:0]   add_i, add_q;
  logic                         ovf_i, ovf_q;

  always_comb begin
    {ovf_i, add_i} = acc_add(sum_i_q, ACC_BITS'(pi_q));
    {ovf_q, add_q} = acc_add(sum_q_q, ACC_BITS'(pq_q));
  end

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    cnt_d       = cnt_q;
    sum_i_d     = sum_i_q;
    sum_q_d     = sum_q_q;
    win_ovf_d   = win_ovf_q;
    pi_d        = pi_q;
    pq_d        = pq_q;
    v1_d        = v1_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    out_valid_d = out_valid_q;
    ovf_out_d   = ovf_out_q;

    if (CE) begin
      out_valid_d = 1'b0;
      v1_d        = SAMPLE_VALID;
      if (SAMPLE_VALID) begin
        pi_d = PROD_BITS'(SAMPLE_IN) * PROD_BITS'(COS_VALUE);
        pq_d = PROD_BITS'(SAMPLE_IN) * PROD_BITS'(SIN_VALUE);
      end

      // A period write restarts the window and drops both in-flight products.
      if (PERIOD_WE) begin
        period_d  = PERIOD_IN;
        cnt_d     = '0;
        sum_i_d   = '0;
        sum_q_d   = '0;
        win_ovf_d = 1'b0;
        v1_d      = 1'b0;
      end else if (v1_q && state_q == RUN) begin
        if (cnt_q == period_q - PERIOD_BITS'(1)) begin
          i_out_d     = add_i;
          q_out_d     = add_q;
          out_valid_d = 1'b1;
          ovf_out_d   = win_ovf_q | ovf_i | ovf_q;
          cnt_d       = '0;
          sum_i_d     = '0;
          sum_q_d     = '0;
          win_ovf_d   = 1'b0;
        end else begin
          cnt_d     = cnt_q + PERIOD_BITS'(1);
          sum_i_d   = add_i;
          sum_q_d   = add_q;
          win_ovf_d = win_ovf_q | ovf_i | ovf_q;
        end
      end

      state_d = (period_d != '0) ? RUN : IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      period_q    <= '0;
      cnt_q       <= '0;
      sum_i_q     <= '0;
      sum_q_q     <= '0;
      win_ovf_q   <= 1'b0;
      pi_q        <= '0;
      pq_q        <= '0;
      v1_q        <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
      ovf_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      sum_i_q     <= sum_i_d;
      sum_q_q     <= sum_q_d;
      win_ovf_q   <= win_ovf_d;
      pi_q        <= pi_d;
      pq_q        <= pq_d;
      v1_q        <= v1_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
      ovf_out_q   <= ovf_out_d;
    end
  end

  assign I_OUT     = i_out_q;
  assign Q_OUT     = q_out_q;
  assign OUT_VALID = out_valid_q;
  assign OVF_OUT   = ovf_out_q;

endmodule
